// File: rtl/onfi_pkg.sv
// Shared ONFI definitions: opcodes, default SDR timing and the command/address sequencer state type.
package onfi_pkg;

  localparam logic [7:0] OP_READ_1      = 8'h00;
  localparam logic [7:0] OP_READ_2      = 8'h30;
  localparam logic [7:0] OP_PROGRAM_1   = 8'h80;
  localparam logic [7:0] OP_PROGRAM_2   = 8'h10;
  localparam logic [7:0] OP_ERASE_1     = 8'h60;
  localparam logic [7:0] OP_ERASE_2     = 8'hD0;
  localparam logic [7:0] OP_READ_ID     = 8'h90;
  localparam logic [7:0] OP_READ_STATUS = 8'h70;
  localparam logic [7:0] OP_RESET       = 8'hFF;

  localparam int unsigned DEF_TWP_CYC     = 3;
  localparam int unsigned DEF_TWH_CYC     = 2;
  localparam int unsigned DEF_TWB_CYC     = 5;
  localparam int unsigned DEF_TIMEOUT_CYC = 65535;
  localparam int unsigned DEF_MAX_ADDR    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD1,
    ST_ADDR,
    ST_CMD2,
    ST_TWB,
    ST_WAIT_RB,
    ST_DONE
  } seq_state_t;

  function automatic logic [2:0] clamp_naddr(input logic [2:0] n, input int unsigned max_addr);
    return (32'(n) > max_addr) ? 3'(max_addr) : n;
  endfunction

endpackage

// File: rtl/onfi_we_strobe.sv
// WE# pacing for one latched byte: TWP_CYC cycles low then TWH_CYC cycles high, slot_end on the last cycle.
module onfi_we_strobe
  import onfi_pkg::*;
#(
  parameter int unsigned TWP_CYC = DEF_TWP_CYC,
  parameter int unsigned TWH_CYC = DEF_TWH_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic we_n,
  output logic slot_end
);

  localparam int unsigned SLOT_CYC = TWP_CYC + TWH_CYC;
  localparam int unsigned CW       = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] LAST   = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] LOW_N  = CW'(TWP_CYC);

  logic          busy;
  logic [CW-1:0] cnt;

  // A start coinciding with slot_end restarts the count, giving gapless back-to-back slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if (cnt == LAST) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign we_n     = !(busy && (cnt < LOW_N));
  assign slot_end = busy && (cnt == LAST);

endmodule

// File: rtl/onfi_cmd_addr_seq.sv
// ONFI SDR command/address cycle sequencer: cmd1, up to MAX_ADDR address bytes, optional cmd2, optional R/B# wait.
module onfi_cmd_addr_seq
  import onfi_pkg::*;
#(
  parameter int unsigned TWP_CYC     = DEF_TWP_CYC,
  parameter int unsigned TWH_CYC     = DEF_TWH_CYC,
  parameter int unsigned TWB_CYC     = DEF_TWB_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned MAX_ADDR    = DEF_MAX_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd1,
  input  logic [2:0]  req_naddr,
  input  logic [39:0] req_addr,
  input  logic        req_has_cmd2,
  input  logic [7:0]  req_cmd2,
  input  logic        req_wait_rb,
  input  logic        rb_n,
  output logic        ce_n,
  output logic        cle,
  output logic        ale,
  output logic        we_n,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  output logic        done,
  output logic        err
);

  localparam int unsigned BW = $clog2(TWB_CYC + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BW-1:0] TWB_LAST  = BW'(TWB_CYC - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);

  seq_state_t    state, state_nx;
  logic [7:0]    cmd1_q, cmd2_q;
  logic [2:0]    naddr_q, addr_cnt;
  logic [39:0]   addr_sh;
  logic          has_cmd2_q, wait_rb_q, err_q;
  logic [BW-1:0] twb_cnt;
  logic [WW-1:0] wait_cnt;
  logic          rb_meta, rb_sync;
  logic          start, slot_end, accept;
  seq_state_t    tail_state;

  onfi_we_strobe #(
    .TWP_CYC (TWP_CYC),
    .TWH_CYC (TWH_CYC)
  ) u_we_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .we_n     (we_n),
    .slot_end (slot_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rb_meta <= 1'b0;
      rb_sync <= 1'b0;
    end else begin
      rb_meta <= rb_n;
      rb_sync <= rb_meta;
    end
  end

  assign accept     = (state == ST_IDLE) && req_valid;
  assign tail_state = wait_rb_q ? ST_TWB : ST_DONE;

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      ST_IDLE: if (req_valid) begin
        state_nx = ST_CMD1;
        start    = 1'b1;
      end
      ST_CMD1: if (slot_end) begin
        if (naddr_q != 3'd0) begin
          state_nx = ST_ADDR;
          start    = 1'b1;
        end else if (has_cmd2_q) begin
          state_nx = ST_CMD2;
          start    = 1'b1;
        end else begin
          state_nx = tail_state;
        end
      end
      ST_ADDR: if (slot_end) begin
        if (addr_cnt != naddr_q - 3'd1) begin
          start = 1'b1;
        end else if (has_cmd2_q) begin
          state_nx = ST_CMD2;
          start    = 1'b1;
        end else begin
          state_nx = tail_state;
        end
      end
      ST_CMD2:    if (slot_end) state_nx = tail_state;
      ST_TWB:     if (twb_cnt == TWB_LAST) state_nx = ST_WAIT_RB;
      ST_WAIT_RB: if (rb_sync || (wait_cnt == WAIT_LAST)) state_nx = ST_DONE;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cmd1_q     <= '0;
      cmd2_q     <= '0;
      naddr_q    <= '0;
      addr_sh    <= '0;
      has_cmd2_q <= 1'b0;
      wait_rb_q  <= 1'b0;
      addr_cnt   <= '0;
      twb_cnt    <= '0;
      wait_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      state    <= state_nx;
      twb_cnt  <= (state == ST_TWB) ? twb_cnt + 1'b1 : '0;
      wait_cnt <= (state == ST_WAIT_RB) ? wait_cnt + 1'b1 : '0;
      if (accept) begin
        cmd1_q     <= req_cmd1;
        cmd2_q     <= req_cmd2;
        naddr_q    <= clamp_naddr(req_naddr, MAX_ADDR);
        addr_sh    <= req_addr;
        has_cmd2_q <= req_has_cmd2;
        wait_rb_q  <= req_wait_rb;
        addr_cnt   <= '0;
        err_q      <= 1'b0;
      end
      // Shifting the address keeps the current byte at [7:0], avoiding a variable part-select.
      if ((state == ST_ADDR) && slot_end) begin
        addr_cnt <= addr_cnt + 1'b1;
        addr_sh  <= addr_sh >> 8;
      end
      if ((state == ST_WAIT_RB) && (state_nx == ST_DONE)) err_q <= !rb_sync;
    end
  end

  always_comb begin
    dq_out = '0;
    unique case (state)
      ST_CMD1: dq_out = cmd1_q;
      ST_ADDR: dq_out = addr_sh[7:0];
      ST_CMD2: dq_out = cmd2_q;
      default: dq_out = '0;
    endcase
  end

  assign req_ready = (state == ST_IDLE);
  assign ce_n      = (state == ST_IDLE) || (state == ST_DONE);
  assign cle       = (state == ST_CMD1) || (state == ST_CMD2);
  assign ale       = (state == ST_ADDR);
  assign dq_oe     = cle || ale;
  assign done      = (state == ST_DONE);
  assign err       = err_q;

endmodule
